data_cache_wb: RTL and testbench
================================

Name: data_cache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache with one-word lines.
- Sits in the MEM stage directly downstream of the store-merge logic:
  - it supplies the addressed cache word (rdata) that the merger combines with store data;
  - it consumes the merged word (wdata) on store hits.
- A miss stalls the pipeline while the FSM writes back a dirty victim and refills from main memory over a simple req/ready handshake.

Parameters:
- WIDTH, 32, data and address width in bits.
- SETS, 256, number of lines; power of two. IDX = log2(SETS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  WIDTH  byte address. Bits [1:0] are the offset and are ignored here. Bits [IDX+1:2] are the index. Bits [WIDTH-1:IDX+2] are the tag.
- rd_en  in  1  load request.
- wr_en  in  1  store request.
- wdata  in  WIDTH  full merged store word.
- rdata  out  WIDTH  data array word at the indexed line. Combinational, driven regardless of hit.
- stall  out  1  high while the request cannot complete this cycle.
- mem_addr  out  WIDTH  word-aligned memory address.
- mem_wdata  out  WIDTH  victim word to write back.
- mem_rd  out  1  refill request.
- mem_wr  out  1  write-back request.
- mem_rdata  in  WIDTH  refill data.
- mem_ready  in  1  memory completes the current mem_rd/mem_wr this cycle.

Behaviour:
- Storage per line: valid, dirty, tag, data word. Reset clears all valid and dirty bits; data and tag arrays are not reset.
- Reset values: state=IDLE, stall=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata = data[index] (undefined contents).
- Hit definition: hit = valid[idx] && tag[idx]==addr tag.
- Request: req = rd_en | wr_en. If both are high, the request is treated as a store.
- stall is combinational:
  - high when req && !hit in IDLE;
  - high whenever state != IDLE.
- Hit latency is 0: a load returns rdata the same cycle. A store hit with stall=0 writes data<=wdata and dirty<=1 at the next edge.
- FSM state IDLE:
  - on req && !hit, go to WRITEBACK if the victim is valid && dirty, else go to REFILL;
  - no array writes occur on a miss cycle.
- FSM state WRITEBACK:
  - mem_wr=1, mem_addr={victim tag, idx, 2'b00}, mem_wdata=data[idx];
  - on mem_ready, go to REFILL.
- FSM state REFILL:
  - mem_rd=1, mem_addr={addr tag, idx, 2'b00};
  - on mem_ready: data<=mem_rdata, tag<=addr tag, valid<=1, dirty<=0, go to IDLE.
- After REFILL, the request is retried in IDLE and now hits. A store then merges against the refilled rdata and writes on that cycle. Refill never writes wdata directly.
- mem_rd and mem_wr are never high together. Both are held high until mem_ready.
- Miss cost:
  - clean miss = 1 + Nrefill cycles of stall;
  - dirty miss = 1 + Nwb + Nrefill cycles.
- The requester holds addr, rd_en, wr_en and wdata stable while stall=1. Behaviour is undefined if they change.
- mem_ready in IDLE is ignored.
- A request deasserted in IDLE: no action, stall=0.
- Reset asserted mid-miss: immediately return to IDLE, drop mem_rd/mem_wr, invalidate all lines, and write no partial refill.
- Index wrap: addresses differing only above the index bits conflict on the same line. The last fill wins, with write-back if dirty.

Optional Feature:
- Macro: DATA_CACHE_STATS_EN.
- When defined: adds ports hit_count and miss_count (out, 32 each).
  - Counters clear on rst.
  - hit_count increments on each IDLE cycle with req && hit.
  - miss_count increments once per miss, on the IDLE→WRITEBACK/REFILL transition.
  - Counters saturate at 32'hFFFF_FFFF.
- When not defined: no ports, no counters; behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg:
  - enum cache_state_t {IDLE, WRITEBACK, REFILL};
  - localparams for the offset width (2) and the tag/index width functions of WIDTH and SETS.
- One natural sub-module: cache_tag_array. It holds the valid/dirty/tag storage and produces hit and victim_dirty. The data array and FSM stay in data_cache_wb.

Test Plan:
- Reset, then load addr 0x0000_0040 with memory word 0xDEAD_BEEF, mem_ready after 3 cycles:
  - stall high for 4 cycles;
  - exactly one mem_rd pulse train with mem_addr=0x40;
  - then rdata=0xDEAD_BEEF with stall=0;
  - a repeat load hits with 0 stall.
- Store hit to 0x40 with wdata=0x1234_5678:
  - no memory traffic;
  - next-cycle load returns 0x1234_5678 and the line is dirty.
- Conflict load to 0x0000_0440 (same index 0x10, different tag) after that dirty store:
  - WRITEBACK with mem_addr=0x40, mem_wdata=0x1234_5678;
  - then REFILL with mem_addr=0x440;
  - mem_wr and mem_rd never overlap.
- Store miss to clean line 0x80 (memory 0xAAAA_AAAA), merged wdata=0xAAAA_AA55:
  - refill first;
  - the store commits on the retry cycle;
  - line becomes dirty with 0xAAAA_AA55.
- Assert rst during REFILL, before mem_ready:
  - mem_rd drops immediately;
  - a subsequent load to the same address misses again.
- With DATA_CACHE_STATS_EN defined, the above sequence gives exact hit/miss counts:
  - misses = 0x40 cold, 0x440, 0x80 cold, and the 0x40 re-miss after the reset;
  - note the counters clear on rst.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the write-back data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } cache_state_t;

  localparam int unsigned OFF_W = 2;

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned width, input int unsigned sets);
    return width - $clog2(sets) - OFF_W;
  endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Valid/dirty/tag storage for a direct-mapped cache; produces hit and victim status.
module cache_tag_array
  import cache_pkg::*;
#(
  parameter int unsigned SETS = 256,
  parameter int unsigned IDX  = 8,
  parameter int unsigned TAG  = 22
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDX-1:0] i_idx,
  input  logic [TAG-1:0] i_tag,
  input  logic           i_fill,
  input  logic           i_set_dirty,
  output logic           o_hit,
  output logic           o_victim_dirty,
  output logic [TAG-1:0] o_victim_tag
);

  logic [SETS-1:0] r_valid;
  logic [SETS-1:0] r_dirty;
  logic [TAG-1:0]  r_tag [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_set_dirty) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tags carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (i_fill) r_tag[i_idx] <= i_tag;
  end

  assign o_hit          = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
  assign o_victim_dirty = r_valid[i_idx] && r_dirty[i_idx];
  assign o_victim_tag   = r_tag[i_idx];

endmodule

// File: rtl/data_cache_wb.sv
// Direct-mapped write-back, write-allocate data cache with one-word lines.
// Optional hit/miss counters enabled by defining DATA_CACHE_STATS_EN.
module data_cache_wb
  import cache_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SETS  = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int unsigned IDX = idx_width(SETS);
  localparam int unsigned TAG = tag_width(WIDTH, SETS);

  cache_state_t r_state, w_next;

  logic [IDX-1:0]   w_idx;
  logic [TAG-1:0]   w_tag;
  logic [TAG-1:0]   w_victim_tag;
  logic             w_hit, w_victim_dirty, w_req, w_fill, w_store_hit;
  logic             w_unused_ofs;
  logic [WIDTH-1:0] r_data [SETS];

  assign w_idx        = addr[IDX+OFF_W-1:OFF_W];
  assign w_tag        = addr[WIDTH-1:IDX+OFF_W];
  assign w_unused_ofs = ^addr[OFF_W-1:0];
  assign w_req        = rd_en | wr_en;
  assign w_fill       = (r_state == REFILL) && mem_ready;
  assign w_store_hit  = (r_state == IDLE) && wr_en && w_hit;

  cache_tag_array #(
    .SETS (SETS),
    .IDX  (IDX),
    .TAG  (TAG)
  ) u_tags (
    .clk            (clk),
    .rst            (rst),
    .i_idx          (w_idx),
    .i_tag          (w_tag),
    .i_fill         (w_fill),
    .i_set_dirty    (w_store_hit),
    .o_hit          (w_hit),
    .o_victim_dirty (w_victim_dirty),
    .o_victim_tag   (w_victim_tag)
  );

  // Refill writes memory data only; a store merges on the retry cycle.
  always_ff @(posedge clk) begin
    if (w_fill)           r_data[w_idx] <= mem_rdata;
    else if (w_store_hit) r_data[w_idx] <= wdata;
  end

  assign rdata = r_data[w_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_req && !w_hit) w_next = w_victim_dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ready) w_next = REFILL;
      REFILL:    if (mem_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: stall = w_req && !w_hit;
      WRITEBACK: begin
        stall     = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {w_victim_tag, w_idx, {OFF_W{1'b0}}};
        mem_wdata = r_data[w_idx];
      end
      REFILL: begin
        stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
      end
      default: stall = 1'b1;
    endcase
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == IDLE && w_req) begin
      if (w_hit && r_hit_cnt != '1)   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (!w_hit && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_data_cache_wb.sv
// Directed self-checking bench for data_cache_wb with a latency-configurable memory responder.
module tb_data_cache_wb;

  localparam int MEM_LAT = 3;

  logic        clk, rst;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        rd_en, wr_en, stall, mem_rd, mem_wr, mem_ready;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache_wb #(.WIDTH(32), .SETS(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_model [logic [31:0]];

  int          n_stall, n_rd, n_wr, n_rd_trains, n_overlap;
  logic [31:0] wb_addr, wb_data, rf_addr, done_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request held until stall clears; the memory answers after MEM_LAT cycles.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    int   cnt;
    logic prev_rd;
    n_stall = 0; n_rd = 0; n_wr = 0; n_rd_trains = 0; n_overlap = 0;
    wb_addr = '0; wb_data = '0; rf_addr = '0; cnt = 0; prev_rd = 1'b0;
    @(posedge clk); #1;
    addr = a; rd_en = rd; wr_en = wr; wdata = wd; mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 40 && stall; i++) begin
      if (mem_rd && !prev_rd) n_rd_trains++;
      prev_rd = mem_rd;
      if (mem_rd) begin n_rd++; rf_addr = mem_addr; end
      if (mem_wr) begin n_wr++; wb_addr = mem_addr; wb_data = mem_wdata; end
      if (mem_rd && mem_wr) n_overlap++;
      if (mem_rd || mem_wr) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          mem_ready = 1'b1;
          cnt = 0;
          if (mem_wr) mem_model[mem_addr] = mem_wdata;
          if (mem_rd) mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        end
      end
      n_stall++;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      #1;
    end
    done_rdata = rdata;
    check("req_done", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    mem_model[32'h0000_0040] = 32'hDEAD_BEEF;
    mem_model[32'h0000_0440] = 32'hCAFE_F00D;
    mem_model[32'h0000_0080] = 32'hAAAA_AAAA;
    mem_model[32'h0000_0480] = 32'h0BAD_F00D;

    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // mem_ready with no request must be ignored
    @(posedge clk); #1;
    mem_ready = 1'b1; #1;
    check("idle_ready_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0; #1;
    check("idle_ready_mem_rd", 32'(mem_rd), 32'd0);
    check("idle_ready_mem_wr", 32'(mem_wr), 32'd0);

    // cold load miss
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("cold_stall", n_stall, 4);
    check("cold_rd_cycles", n_rd, 3);
    check("cold_rd_trains", n_rd_trains, 1);
    check("cold_wr_cycles", n_wr, 0);
    check("cold_rf_addr", rf_addr, 32'h0000_0040);
    check("cold_rdata", done_rdata, 32'hDEAD_BEEF);

    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("rehit_stall", n_stall, 0);
    check("rehit_rdata", done_rdata, 32'hDEAD_BEEF);

    // store hit, then read it back
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
    check("st_hit_stall", n_stall, 0);
    check("st_hit_traffic", n_rd + n_wr, 0);
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("st_read_stall", n_stall, 0);
    check("st_read_rdata", done_rdata, 32'h1234_5678);

    // conflict on index 0x10 evicts the dirty 0x40 line
    do_req(1'b1, 1'b0, 32'h0000_0440, 32'h0);
    check("conf_stall", n_stall, 7);
    check("conf_wb_addr", wb_addr, 32'h0000_0040);
    check("conf_wb_data", wb_data, 32'h1234_5678);
    check("conf_rf_addr", rf_addr, 32'h0000_0440);
    check("conf_overlap", n_overlap, 0);
    check("conf_rdata", done_rdata, 32'hCAFE_F00D);

    // store miss to a clean line: refill, then merge on retry
    do_req(1'b0, 1'b1, 32'h0000_0080, 32'hAAAA_AA55);
    check("stmiss_stall", n_stall, 4);
    check("stmiss_wr_cycles", n_wr, 0);
    check("stmiss_rf_addr", rf_addr, 32'h0000_0080);
    check("stmiss_retry_rdata", done_rdata, 32'hAAAA_AAAA);
    do_req(1'b1, 1'b0, 32'h0000_0080, 32'h0);
    check("stmiss_read_stall", n_stall, 0);
    check("stmiss_read_rdata", done_rdata, 32'hAAAA_AA55);

    // dirty evidence: evicting 0x80 writes the merged word back
    do_req(1'b1, 1'b0, 32'h0000_0480, 32'h0);
    check("evict80_stall", n_stall, 7);
    check("evict80_wb_addr", wb_addr, 32'h0000_0080);
    check("evict80_wb_data", wb_data, 32'hAAAA_AA55);
    check("evict80_rdata", done_rdata, 32'h0BAD_F00D);

`ifdef DATA_CACHE_STATS_EN
    check("stat_hits_pre", hit_count, 32'd8);
    check("stat_miss_pre", miss_count, 32'd4);
`endif

    // reset in the middle of a refill
    @(posedge clk); #1;
    addr = 32'h0000_0040; rd_en = 1'b1; #1;
    check("mid_miss_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("mid_refill_rd", 32'(mem_rd), 32'd1);
    check("mid_refill_addr", mem_addr, 32'h0000_0040);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    check("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // 0x40 misses again; memory now holds the written-back store data
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("post_rst_stall", n_stall, 4);
    check("post_rst_rf_addr", rf_addr, 32'h0000_0040);
    check("post_rst_rdata", done_rdata, 32'h1234_5678);

`ifdef DATA_CACHE_STATS_EN
    check("stat_hits_post", hit_count, 32'd1);
    check("stat_miss_post", miss_count, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
